fx_eq_biquad: RTL and testbench

//  Parametrised EQ stage (FX 2): N_BANDS cascaded direct-form-I biquads on each of N_CH channels.
//  One shared MAC is time-multiplexed over all channels and bands.
//  A host loads coefficients into a shadow bank and commits them atomically between samples.

---
 rtl/fx_eq_pkg.sv | 47 ++++
 rtl/fx_eq_biquad_mac.sv | 59 +++++
 rtl/fx_eq_biquad.sv | 210 +++++++++++++++++++++
 tb/tb_fx_eq_biquad.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_eq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fx_eq_pkg                                                    |
// | Description : Shared enums, constants and rounding helper for the EQ stage |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package fx_eq_pkg;

    typedef enum logic [2:0] {
        C_B0 = 3'd0,
        C_B1 = 3'd1,
        C_B2 = 3'd2,
        C_A1 = 3'd3,
        C_A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_WB   = 3'd3,
        S_BYP  = 3'd4,
        S_DONE = 3'd5
    } eq_state_e;

    localparam int N_COEF        = 5;
    // Coefficients are Q2.(COEF_W-2): unity is 1 << (COEF_W - COEF_INT_BITS)
    localparam int COEF_INT_BITS = 2;

    // Round half up, drop FRAC bits, clamp to a DATA_W-bit signed range.
    function automatic longint sat_round(input longint acc, input int frac, input int data_w);
        longint r;
        longint hi;
        longint lo;
        r  = (acc + (longint'(1) <<< (frac - 1))) >>> frac;
        hi = (longint'(1) <<< (data_w - 1)) - 1;
        lo = -(longint'(1) <<< (data_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fx_eq_biquad_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fx_eq_biquad_mac                                             |
// | Description : Registered multiplier feeding an add/sub accumulator         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fx_eq_biquad_mac
    import fx_eq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int ACC_W  = DATA_W + COEF_W + 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mul_en,
    input  logic                     sub,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    input  logic signed [DATA_W-1:0] data,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [DATA_W-1:0] y
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_sub;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_base;

    assign w_a    = $signed({{COEF_W{data[DATA_W-1]}}, data});
    assign w_b    = $signed({{DATA_W{coef[COEF_W-1]}}, coef});
    assign w_term = $signed({{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod});
    assign w_base = acc_clr ? '0 : r_acc;

    // The subtract flag travels with its product so feedback terms line up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod <= '0;
            r_sub  <= 1'b0;
            r_acc  <= '0;
        end else begin
            if (mul_en) begin
                r_prod <= w_a * w_b;
                r_sub  <= sub;
            end
            if (acc_en) begin
                r_acc <= r_sub ? (w_base - w_term) : (w_base + w_term);
            end
        end
    end

    assign y = DATA_W'(sat_round(longint'(r_acc), COEF_W - COEF_INT_BITS, DATA_W));

endmodule
`default_nettype wire

// File: rtl/fx_eq_biquad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fx_eq_biquad                                                 |
// | Description : Multi-channel cascaded DF-I biquad EQ on one shared MAC      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fx_eq_biquad
    import fx_eq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int N_CH    = 2,
    parameter int N_BANDS = 4,
    parameter int COEF_W  = 18,
    parameter int ADDR_W  = $clog2(N_BANDS * 5)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_CH-1:0][DATA_W-1:0]  audio_in,
    input  logic                         bypass,
    output logic                         out_valid,
    output logic [N_CH-1:0][DATA_W-1:0]  audio_out,
    input  logic                         coef_wr_en,
    input  logic [ADDR_W-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0]     coef_wr_data,
    input  logic                         coef_commit,
    output logic                         commit_pend
);
    localparam int N_COEFS = N_BANDS * N_COEF;
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BAND_W  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int ACC_W   = DATA_W + COEF_W + 3;
    localparam int H_X1 = 0, H_X2 = 1, H_Y1 = 2, H_Y2 = 3;
    localparam logic signed [COEF_W-1:0] C_COEF_ONE = COEF_W'(1) << (COEF_W - COEF_INT_BITS);

    eq_state_e                   r_state;
    logic [CH_W-1:0]             r_ch;
    logic [BAND_W-1:0]           r_band;
    logic [2:0]                  r_term;
    logic [N_CH-1:0][DATA_W-1:0] r_frame;
    logic [N_CH-1:0][DATA_W-1:0] r_out;
    logic                        r_out_valid;
    logic                        r_commit_pend;
    logic signed [DATA_W-1:0]    r_x;
    logic signed [DATA_W-1:0]    r_hist   [N_CH][N_BANDS][4];
    logic signed [COEF_W-1:0]    r_shadow [N_COEFS];
    logic signed [COEF_W-1:0]    r_active [N_COEFS];

    coef_idx_e                   w_sel;
    logic [ADDR_W-1:0]           w_cidx;
    logic signed [DATA_W-1:0]    w_x;
    logic signed [DATA_W-1:0]    w_data;
    logic signed [DATA_W-1:0]    w_y;
    logic                        w_copy;
    logic                        w_mul_en;
    logic                        w_acc_en;
    logic                        w_acc_clr;
    logic                        w_sub;

    // Multiplier runs one term ahead of the accumulator: LOAD feeds b0*x.
    always_comb begin
        w_sel = C_B0;
        if (r_state == S_MAC) begin
            case (r_term)
                3'd0:    w_sel = C_B1;
                3'd1:    w_sel = C_B2;
                3'd2:    w_sel = C_A1;
                default: w_sel = C_A2;
            endcase
        end
    end

    assign w_x    = (r_band == '0) ? $signed(r_frame[r_ch]) : r_x;
    assign w_cidx = ADDR_W'(int'(r_band) * N_COEF + int'(w_sel));

    always_comb begin
        w_data = w_x;
        case (w_sel)
            C_B1:    w_data = r_hist[r_ch][r_band][H_X1];
            C_B2:    w_data = r_hist[r_ch][r_band][H_X2];
            C_A1:    w_data = r_hist[r_ch][r_band][H_Y1];
            C_A2:    w_data = r_hist[r_ch][r_band][H_Y2];
            default: w_data = w_x;
        endcase
    end

    assign w_mul_en  = (r_state == S_LOAD) || ((r_state == S_MAC) && (r_term != 3'd4));
    assign w_acc_en  = (r_state == S_MAC);
    assign w_acc_clr = w_acc_en && (r_term == 3'd0);
    assign w_sub     = (w_sel == C_A1) || (w_sel == C_A2);
    assign w_copy    = (r_state == S_IDLE) && r_commit_pend;

    fx_eq_biquad_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .mul_en  (w_mul_en),
        .sub     (w_sub),
        .acc_en  (w_acc_en),
        .acc_clr (w_acc_clr),
        .data    (w_data),
        .coef    (r_active[w_cidx]),
        .y       (w_y)
    );

    // Shadow reads here see the pre-write value, so a same-cycle write is not copied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_COEFS; i++) begin
                r_shadow[i] <= ((i % N_COEF) == 0) ? C_COEF_ONE : '0;
                r_active[i] <= ((i % N_COEF) == 0) ? C_COEF_ONE : '0;
            end
            r_commit_pend <= 1'b0;
        end else begin
            if (coef_wr_en && (int'(coef_addr) < N_COEFS)) begin
                r_shadow[coef_addr] <= coef_wr_data;
            end
            if (w_copy) begin
                r_active <= r_shadow;
            end
            r_commit_pend <= coef_commit || (r_commit_pend && !w_copy);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_band      <= '0;
            r_term      <= '0;
            r_frame     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            for (int c = 0; c < N_CH; c++) begin
                for (int b = 0; b < N_BANDS; b++) begin
                    for (int h = 0; h < 4; h++) begin
                        r_hist[c][b][h] <= '0;
                    end
                end
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_frame <= audio_in;
                        r_ch    <= '0;
                        r_band  <= '0;
                        r_state <= bypass ? S_BYP : S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_term  <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (r_term == 3'd4) begin
                        r_state <= S_WB;
                    end else begin
                        r_term <= r_term + 3'd1;
                    end
                end
                S_WB: begin
                    r_hist[r_ch][r_band][H_X2] <= r_hist[r_ch][r_band][H_X1];
                    r_hist[r_ch][r_band][H_X1] <= w_x;
                    r_hist[r_ch][r_band][H_Y2] <= r_hist[r_ch][r_band][H_Y1];
                    r_hist[r_ch][r_band][H_Y1] <= w_y;
                    r_x <= w_y;
                    if (r_band == BAND_W'(N_BANDS - 1)) begin
                        r_band       <= '0;
                        r_frame[r_ch] <= w_y;
                        if (r_ch == CH_W'(N_CH - 1)) begin
                            for (int c = 0; c < N_CH; c++) begin
                                r_out[c] <= (CH_W'(c) == r_ch) ? w_y : r_frame[c];
                            end
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_band  <= r_band + 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_BYP: begin
                    r_out       <= r_frame;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign audio_out   = r_out;
    assign commit_pend = r_commit_pend;

endmodule
`default_nettype wire

// File: tb/tb_fx_eq_biquad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fx_eq_biquad                                              |
// | Description : Self-checking bench for fx_eq_biquad against a frame model   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_fx_eq_biquad;

    logic              clk          = 1'b0;
    logic              reset_n      = 1'b0;
    logic              in_valid     = 1'b0;
    logic              bypass       = 1'b0;
    logic              coef_wr_en   = 1'b0;
    logic              coef_commit  = 1'b0;
    logic [4:0]        coef_addr    = '0;
    logic [17:0]       coef_wr_data = '0;
    logic [1:0][15:0]  audio_in     = '0;
    logic [1:0][15:0]  audio_out;
    logic              in_ready;
    logic              out_valid;
    logic              commit_pend;

    int     n_vec = 0;
    int     n_err = 0;
    longint m_shadow [20];
    longint m_active [20];
    longint m_h      [2][4][4];
    bit     m_pend;
    longint g0, g1, rv;

    fx_eq_biquad #(
        .DATA_W  (16),
        .N_CH    (2),
        .N_BANDS (4),
        .COEF_W  (18)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .audio_in     (audio_in),
        .bypass       (bypass),
        .out_valid    (out_valid),
        .audio_out    (audio_out),
        .coef_wr_en   (coef_wr_en),
        .coef_addr    (coef_addr),
        .coef_wr_data (coef_wr_data),
        .coef_commit  (coef_commit),
        .commit_pend  (commit_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd_sat(input longint acc);
        longint r;
        r = (acc + 32768) >>> 16;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic longint rnd_sample();
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 20; i++) begin
            m_shadow[i] = ((i % 5) == 0) ? 65536 : 0;
            m_active[i] = m_shadow[i];
        end
        for (int c = 0; c < 2; c++)
            for (int b = 0; b < 4; b++)
                for (int h = 0; h < 4; h++)
                    m_h[c][b][h] = 0;
        m_pend = 1'b0;
    endtask

    // Each channel runs through the band cascade; history is x1,x2,y1,y2.
    task automatic model_run(input longint i0, input longint i1, output longint o0, output longint o1);
        longint xin [2];
        longint res [2];
        longint x, y, acc;
        xin[0] = i0;
        xin[1] = i1;
        for (int c = 0; c < 2; c++) begin
            x = xin[c];
            for (int b = 0; b < 4; b++) begin
                acc = m_active[b*5] * x + m_active[b*5+1] * m_h[c][b][0] + m_active[b*5+2] * m_h[c][b][1]
                    - m_active[b*5+3] * m_h[c][b][2] - m_active[b*5+4] * m_h[c][b][3];
                y = rnd_sat(acc);
                m_h[c][b][1] = m_h[c][b][0];
                m_h[c][b][0] = x;
                m_h[c][b][3] = m_h[c][b][2];
                m_h[c][b][2] = y;
                x = y;
            end
            res[c] = x;
        end
        o0 = res[0];
        o1 = res[1];
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        bypass      = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic write_coef(input int a, input longint v);
        coef_wr_en   = 1'b1;
        coef_addr    = 5'(a);
        coef_wr_data = 18'(v);
        @(negedge clk);
        coef_wr_en = 1'b0;
        if (a < 20) m_shadow[a] = v;
    endtask

    task automatic commit_pulse();
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        m_pend = 1'b1;
    endtask

    task automatic send_frame(input longint x0, input longint x1, input bit byp, input int commit_at,
                              output longint o0, output longint o1);
        longint e0, e1;
        int n;
        if (m_pend) begin
            m_active = m_shadow;
            m_pend = 1'b0;
        end
        if (byp) begin
            e0 = x0;
            e1 = x1;
        end else begin
            model_run(x0, x1, e0, e1);
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid    = 1'b1;
        bypass      = byp;
        audio_in[0] = 16'(x0);
        audio_in[1] = 16'(x1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        bypass   = 1'b0;
        n = 1;
        check("busy_after_accept", in_ready, 0);
        while (out_valid !== 1'b1 && n < 200) begin
            coef_commit = (n == commit_at);
            if (n == commit_at) m_pend = 1'b1;
            @(negedge clk);
            n++;
        end
        coef_commit = 1'b0;
        check(byp ? "latency_bypass" : "latency_filtered", n, byp ? 2 : 57);
        o0 = $signed(audio_out[0]);
        o1 = $signed(audio_out[1]);
        check("out_ch0", o0, e0);
        check("out_ch1", o1, e1);
        if (commit_at > 0) check("pend_held_in_frame", commit_pend, 1);
        @(negedge clk);
        check("out_valid_one_cycle", out_valid, 0);
        check("ready_after_done", in_ready, 1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out0", $signed(audio_out[0]), 0);
        check("rst_out1", $signed(audio_out[1]), 0);
        check("rst_commit_pend", commit_pend, 0);

        // Identity after reset
        send_frame(1000, -1000, 1'b0, 0, g0, g1);
        check("ident_ch0", g0, 1000);
        check("ident_ch1", g1, -1000);

        // Half gain on band 0, commit from idle
        write_coef(0, 32768);
        commit_pulse();
        check("pend_set", commit_pend, 1);
        @(negedge clk);
        check("pend_cleared", commit_pend, 0);
        send_frame(20000, -32768, 1'b0, 0, g0, g1);
        check("half_ch0", g0, 10000);
        check("half_ch1", g1, -16384);

        // Near-2.0 gain saturates
        write_coef(0, 131071);
        commit_pulse();
        send_frame(32767, -32768, 1'b0, 0, g0, g1);
        check("sat_ch0", g0, 32767);
        check("sat_ch1", g1, -32768);

        // Feedback impulse response with a bypass frame in the middle
        do_reset();
        write_coef(3, -32768);
        commit_pulse();
        send_frame(16384, rnd_sample(), 1'b0, 0, g0, g1);
        check("imp_y0", g0, 16384);
        send_frame(0, rnd_sample(), 1'b0, 0, g0, g1);
        check("imp_y1", g0, 8192);
        rv = rnd_sample();
        send_frame(rv, rnd_sample(), 1'b1, 0, g0, g1);
        check("bypass_pass", g0, rv);
        send_frame(0, rnd_sample(), 1'b0, 0, g0, g1);
        check("imp_y2", g0, 4096);
        send_frame(0, rnd_sample(), 1'b0, 0, g0, g1);
        check("imp_y3", g0, 2048);

        // Commit while busy takes effect only on the following frame
        write_coef(5, 32768);
        send_frame(1000, 2000, 1'b0, 10, g0, g1);
        @(negedge clk);
        check("pend_after_idle_copy", commit_pend, 0);
        send_frame(1000, 2000, 1'b0, 0, g0, g1);

        // Reset mid-MAC aborts the frame and restores identity
        write_coef(0, 32768);
        commit_pulse();
        in_valid    = 1'b1;
        audio_in[0] = 16'(5000);
        audio_in[1] = 16'(-7000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out0", $signed(audio_out[0]), 0);
        check("abort_out1", $signed(audio_out[1]), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        begin
            int ov_cnt;
            ov_cnt = 0;
            repeat (80) begin
                @(negedge clk);
                if (out_valid === 1'b1) ov_cnt++;
            end
            check("abort_no_out_valid", ov_cnt, 0);
        end
        send_frame(1234, -4321, 1'b0, 0, g0, g1);
        check("abort_ident_ch0", g0, 1234);
        check("abort_ident_ch1", g1, -4321);

        // Randomised coefficients and frames
        for (int i = 0; i < 20; i++) begin
            if ((i % 5) < 3) write_coef(i, longint'($urandom_range(0, 131072)) - 65536);
            else             write_coef(i, longint'($urandom_range(0, 32768)) - 16384);
        end
        write_coef(20 + int'($urandom_range(0, 11)), longint'($urandom_range(0, 131071)));
        commit_pulse();
        for (int k = 0; k < 14; k++) begin
            send_frame(rnd_sample(), rnd_sample(), ($urandom_range(0, 3) == 0), 0, g0, g1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
